// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Raises a level interrupt when the last queued byte has left the line.
module uart_tx_buffered #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int FIFO_AW  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    output logic       write_busy,
    output logic       int_req,
    input  logic       int_ack,
    output logic       tx_idle,
    output logic       com_TxD
);

    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] head;
    logic [FIFO_AW-1:0] tail;
    logic [FIFO_AW:0]   count;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;

    logic push;
    logic pop;
    logic bit_done;
    logic drained;

    assign write_busy = (count == FULL);
    assign tx_idle    = (state == IDLE) && (count == '0);
    assign push       = write_enable && !write_busy;
    assign pop        = (state == IDLE) && (count != '0);
    assign bit_done   = (baud_cnt == DIV_M1);
    // count here is the pre-push value, so a same-cycle write still fires it
    assign drained    = (state == STOP) && bit_done && (count == '0);

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[tail] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            com_TxD  <= 1'b1;
            int_req  <= 1'b0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;

            if (drained)
                int_req <= 1'b1;
            else if (int_ack)
                int_req <= 1'b0;

            if (state == IDLE || bit_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    com_TxD <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[head];
                        com_TxD <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        com_TxD <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'd7) begin
                            com_TxD <= 1'b1;
                            state   <= STOP;
                        end else begin
                            com_TxD <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    com_TxD <= 1'b1;
                    if (bit_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a short bit period.
// CLK_FREQ=1155, BAUD=100 -> (1155+50)/100 = 12 cycles per bit.
module tb_uart_tx_buffered;

    localparam int DIV = 12;
    localparam int FRAME = 10 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       write_enable = 1'b0;
    logic       write_busy;
    logic       int_req;
    logic       int_ack = 1'b0;
    logic       tx_idle;
    logic       com_TxD;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    uart_tx_buffered #(
        .CLK_FREQ(1155),
        .BAUD(100),
        .FIFO_AW(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .write_enable(write_enable),
        .write_busy(write_busy),
        .int_req(int_req),
        .int_ack(int_ack),
        .tx_idle(tx_idle),
        .com_TxD(com_TxD)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called at the first sample of the start bit; returns at the
    // first sample after the STOP->IDLE edge.
    task automatic check_frame(input logic [7:0] b, input logic ack_end);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < DIV; c++) begin
                n_vec++;
                if (com_TxD !== f[k]) begin
                    n_err++;
                    $display("FAIL frame_bit byte=%h bit=%0d off=%0d got=%b exp=%b",
                             b, k, c, com_TxD, f[k]);
                end
                if (ack_end && k == 9 && c == DIV - 1)
                    int_ack = 1'b1;
                step();
                int_ack = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_vec++;
        if ({com_TxD, int_req, write_busy, tx_idle} !== 4'b1001) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=1001",
                     {com_TxD, int_req, write_busy, tx_idle});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        data_in = 8'h55;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        n_vec++;
        if (com_TxD !== 1'b1 || tx_idle !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency com=%b idle=%b exp com=1 idle=0",
                     com_TxD, tx_idle);
        end
        step();
        check_frame(8'h55, 1'b0);
        n_vec++;
        if ({int_req, tx_idle, com_TxD} !== 3'b111) begin
            n_err++;
            $display("FAIL single_end got=%b exp=111", {int_req, tx_idle, com_TxD});
        end
    endtask

    task automatic test_int_ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL ack_clear got=%b exp=0", int_req);
        end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        n_vec++;
        if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle got=%b exp=0", int_req);
        end
        data_in = 8'h3C;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        step();
        check_frame(8'h3C, 1'b1);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL ack_vs_set got=%b exp=1", int_req);
        end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic test_fifo_fill();
        int s0;
        int start;
        logic bad;
        s0 = 0;
        for (int i = 0; i < 17; i++) begin
            data_in = 8'(i);
            write_enable = 1'b1;
            step();
            if (i == 1) begin
                s0 = cyc;
                n_vec++;
                if (com_TxD !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_first_start got=%b exp=0", com_TxD);
                end
            end
        end
        n_vec++;
        if (write_busy !== 1'b1) begin
            n_err++;
            $display("FAIL fill_busy got=%b exp=1", write_busy);
        end
        data_in = 8'hAA;
        step();
        write_enable = 1'b0;
        n_vec++;
        if (write_busy !== 1'b1) begin
            n_err++;
            $display("FAIL fill_busy_hold got=%b exp=1", write_busy);
        end
        for (int k = 1; k <= 16; k++) begin
            start = s0 + k * FRAME;
            while (cyc < start - 1)
                step();
            n_vec++;
            if (com_TxD !== 1'b1 || int_req !== 1'b0) begin
                n_err++;
                $display("FAIL fill_gap k=%0d com=%b irq=%b exp com=1 irq=0",
                         k, com_TxD, int_req);
            end
            step();
            if (k == 1) begin
                n_vec++;
                if (write_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_unbusy got=%b exp=0", write_busy);
                end
            end
            check_frame(8'(k), 1'b0);
        end
        n_vec++;
        if (int_req !== 1'b1 || tx_idle !== 1'b1) begin
            n_err++;
            $display("FAIL fill_end irq=%b idle=%b exp 1 1", int_req, tx_idle);
        end
        bad = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) begin
            if (com_TxD !== 1'b1)
                bad = 1'b1;
            step();
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL fill_dropped_sent got=1 exp=0");
        end
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        data_in = 8'h81;
        write_enable = 1'b1;
        step();
        data_in = 8'h7E;
        step();
        write_enable = 1'b0;
        check_frame(8'h81, 1'b0);
        n_vec++;
        if (com_TxD !== 1'b1 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap1 com=%b irq=%b exp 1 0", com_TxD, int_req);
        end
        data_in = 8'hC5;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        check_frame(8'h7E, 1'b0);
        n_vec++;
        if (com_TxD !== 1'b1 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap2 com=%b irq=%b exp 1 0", com_TxD, int_req);
        end
        step();
        check_frame(8'hC5, 1'b0);
        n_vec++;
        if (int_req !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_irq got=%b exp=1", int_req);
        end
    endtask

    task automatic test_reset_mid();
        int s;
        logic bad;
        data_in = 8'hA3;
        write_enable = 1'b1;
        step();
        data_in = 8'h11;
        step();
        s = cyc;
        data_in = 8'h22;
        step();
        data_in = 8'h33;
        step();
        write_enable = 1'b0;
        while (cyc < s + 4 * DIV + 3)
            step();
        n_vec++;
        if (com_TxD !== 1'b0) begin
            n_err++;
            $display("FAIL mid_bit3 got=%b exp=0", com_TxD);
        end
        rst = 1'b1;
        write_enable = 1'b1;
        data_in = 8'h44;
        int_ack = 1'b0;
        step();
        rst = 1'b0;
        write_enable = 1'b0;
        n_vec++;
        if ({com_TxD, tx_idle, int_req, write_busy} !== 4'b1100) begin
            n_err++;
            $display("FAIL mid_reset got=%b exp=1100",
                     {com_TxD, tx_idle, int_req, write_busy});
        end
        bad = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (com_TxD !== 1'b1 || tx_idle !== 1'b1 || int_req !== 1'b0)
                bad = 1'b1;
            step();
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL mid_quiet got=1 exp=0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_int_ack();
        test_fifo_fill();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLK_FREQ, 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.
REQ-004 clk  input  1  clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  8  byte to transmit.
REQ-007 write_enable  input  1  push data_in into FIFO this cycle.
REQ-008 write_busy  output  1  FIFO full; writes ignored while high.
REQ-009 int_req  output  1  transmit-drained interrupt, level, held until acked.
REQ-010 int_ack  input  1  one-cycle interrupt clear.
REQ-011 tx_idle  output  1  high when FSM in IDLE and FIFO empty.
REQ-012 com_TxD  output  1  serial line, registered, idle high.

Function
REQ-013 SHALL use bit period DIV = (CLK_FREQ + BAUD/2) / BAUD cycles (434 at defaults), with a 16-bit baud counter.
REQ-014 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; each bit held on com_TxD for exactly DIV cycles.
REQ-016 Write SHALL be accepted on any cycle with write_enable=1 and write_busy=0; byte stored at tail, count +1.
REQ-017 write_enable while write_busy=1 SHALL be dropped with no state change.
REQ-018 write_busy SHALL equal (count == 2**FIFO_AW), registered-consistent with count in the same cycle.
REQ-019 In IDLE with count != 0: pop head into shift register, go START, clear baud counter, com_TxD <= 0 next cycle.
REQ-020 Push and pop in same cycle SHALL both occur; count unchanged; push SHALL still be accepted when FIFO is full only if a pop occurs that cycle -- no: write_busy governs, full-cycle writes are dropped.
REQ-021 START -> DATA after DIV cycles; DATA shifts out 8 bits, bit index 0..7, -> STOP after 8*DIV cycles; STOP -> IDLE after DIV cycles.
REQ-022 Back-to-back bytes SHALL be spaced 10*DIV + 1 cycles start-edge to start-edge (one IDLE cycle between frames).
REQ-023 First start bit SHALL appear on com_TxD 2 cycles after the accepting write edge when FSM idle and FIFO empty (write edge, pop edge, then line low).
REQ-024 FIFO pointers SHALL wrap modulo 2**FIFO_AW; count width FIFO_AW+1.
REQ-025 int_req SHALL set on the STOP->IDLE transition cycle when count == 0 before any push that cycle.
REQ-026 int_ack SHALL clear int_req; if set and ack coincide, set SHALL win (int_req stays 1).
REQ-027 int_ack while int_req=0 SHALL have no effect.
REQ-028 com_TxD SHALL be 1 in IDLE and STOP.

Reset
REQ-029 On rst: com_TxD=1, int_req=0, write_busy=0, tx_idle=1, state IDLE, pointers and count 0, baud counter 0.
REQ-030 rst mid-frame SHALL abort the frame, drive com_TxD=1 from the next cycle, discard all FIFO contents; rst has priority over write and int_ack.

Verification
REQ-031 Write 0x55 once from idle -> com_TxD: 0 (start), 1,0,1,0,1,0,1,0, 1 (stop), each 434 cycles; int_req rises at frame end; tx_idle=1 after.
REQ-032 Write 17 bytes 0x00..0x10 on consecutive cycles with FIFO_AW=4 -> first popped immediately, 16 queued, write_busy=1 briefly, any write while busy dropped; all accepted bytes emitted in order, 4341 cycles apart.
REQ-033 int_ack pulsed while int_req=1 -> int_req=0 next cycle; ack coincident with frame-end set -> int_req remains 1.
REQ-034 rst asserted in DATA bit 3 of 0xA3 with 3 bytes queued -> com_TxD=1 next cycle, tx_idle=1, no further frames, int_req=0.
REQ-035 Write on same cycle IDLE pops last byte -> count unchanged, new byte transmitted next with 1-cycle gap; no int_req between the two frames.
